// File: rtl/lv1_il_mw_pkg.sv
// Shared types and address-field helpers for the multi-word L1 instruction cache block.
package lv1_il_mw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_REQ,
        S_RD,
        S_FILL,
        S_INV
    } ilState_e;

    localparam logic INVALID = 1'b0;
    localparam logic VALID   = 1'b1;

    // Register width for a counter/index over n items; never narrower than one bit.
    function automatic int fieldWid(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int offBits(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    function automatic int idxLsb(input int lineWords);
        return 2 + offBits(lineWords);
    endfunction

    function automatic int tagLsb(input int lineWords, input int sets);
        return idxLsb(lineWords) + offBits(sets);
    endfunction

endpackage

// File: rtl/lv1_il_victim_sel.sv
// Victim way selection: lowest invalid way wins, otherwise the per-set round-robin pointer.
module lv1_il_victim_sel
    import lv1_il_mw_pkg::*;
#(
    parameter int ASSOC     = 4,
    parameter int ASSOC_WID = 2,
    parameter int SETS      = 64,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     set_i,
    input  logic [ASSOC-1:0]     valid_i,
    input  logic                 clr_en_i,
    input  logic [IDX_W-1:0]     clr_set_i,
    input  logic                 adv_en_i,
    output logic [ASSOC_WID-1:0] victim_o
);

    logic [ASSOC_WID-1:0] rrPtr_q [SETS];

    always_comb begin
        victim_o = rrPtr_q[set_i];
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (valid_i[w] == INVALID) begin
                victim_o = ASSOC_WID'(w);
            end
        end
    end

    // The pointer relies on ASSOC being a power of two to wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rrPtr_q[s] <= '0;
            end
        end else begin
            if (clr_en_i) begin
                rrPtr_q[clr_set_i] <= '0;
            end
            if (adv_en_i) begin
                rrPtr_q[set_i] <= rrPtr_q[set_i] + ASSOC_WID'(1);
            end
        end
    end

endmodule

// File: rtl/cache_block_lv1_il_mw.sv
// N-way multi-word L1 instruction cache block with line fill and bulk invalidate.
// Optional hit/miss perf counters are built when CACHE_IL_PERF_CNT_EN is defined.
module cache_block_lv1_il_mw
    import lv1_il_mw_pkg::*;
#(
    parameter int ASSOC      = 4,
    parameter int ASSOC_WID  = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WID   = 32,
    parameter int DATA_WID   = 32
`ifdef CACHE_IL_PERF_CNT_EN
    , parameter int CNT_WID  = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_rd,
    input  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1,
    output logic [DATA_WID-1:0]  data_bus_cpu_lv1,
    output logic                 data_in_bus_cpu_lv1_il,
    output logic                 bus_lv1_lv2_req_proc_il,
    input  logic                 bus_lv1_lv2_gnt_proc,
    output logic                 lv2_rd,
    output logic [ADDR_WID-1:0]  addr_bus_lv1_lv2,
    input  logic [DATA_WID-1:0]  data_bus_lv1_lv2,
    input  logic                 data_in_bus_lv1_lv2,
    input  logic                 inv_all,
    output logic                 inv_busy,
`ifdef CACHE_IL_PERF_CNT_EN
    output logic [CNT_WID-1:0]   hit_cnt,
    output logic [CNT_WID-1:0]   miss_cnt,
`endif
    output logic [ASSOC_WID-1:0] blk_accessed_main
);

    localparam int OFF_W   = fieldWid(LINE_WORDS);
    localparam int IDX_W   = fieldWid(SETS);
    localparam int IDX_LSB = idxLsb(LINE_WORDS);
    localparam int TAG_LSB = tagLsb(LINE_WORDS, SETS);
    localparam int TAG_W   = ADDR_WID - TAG_LSB;
    localparam logic [ADDR_WID-1:0] OFF_MASK  = ADDR_WID'(LINE_WORDS - 1);
    localparam logic [ADDR_WID-1:0] LINE_MASK = ADDR_WID'(LINE_WORDS * 4 - 1);

    logic [TAG_W-1:0]    tagArr_q   [SETS][ASSOC];
    logic [DATA_WID-1:0] dataArr_q  [SETS][ASSOC][LINE_WORDS];
    logic [ASSOC-1:0]    validArr_q [SETS];
    logic [DATA_WID-1:0] fillBuf_q  [LINE_WORDS];

    ilState_e             state_q, state_d;
    logic [OFF_W-1:0]     beatCnt_q, beatCnt_d;
    logic [IDX_W-1:0]     invIdx_q, invIdx_d;
    logic                 invPend_q, invPend_d;
    logic [ADDR_WID-1:0]  missAddr_q, missAddr_d;
    logic [DATA_WID-1:0]  rspData_q, rspData_d;
    logic [ASSOC_WID-1:0] rspWay_q, rspWay_d;

    logic [OFF_W-1:0]     cpuOff, missOff;
    logic [IDX_W-1:0]     cpuIdx, missIdx;
    logic [TAG_W-1:0]     cpuTag, missTag;
    logic                 cpuHit;
    logic [ASSOC_WID-1:0] hitWay, victimWay;

    assign cpuOff  = OFF_W'((addr_bus_cpu_lv1 >> 2) & OFF_MASK);
    assign cpuIdx  = IDX_W'(addr_bus_cpu_lv1 >> IDX_LSB);
    assign cpuTag  = TAG_W'(addr_bus_cpu_lv1 >> TAG_LSB);
    assign missOff = OFF_W'((missAddr_q >> 2) & OFF_MASK);
    assign missIdx = IDX_W'(missAddr_q >> IDX_LSB);
    assign missTag = TAG_W'(missAddr_q >> TAG_LSB);

    always_comb begin
        cpuHit = 1'b0;
        hitWay = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (validArr_q[cpuIdx][w] == VALID && tagArr_q[cpuIdx][w] == cpuTag) begin
                cpuHit = 1'b1;
                hitWay = ASSOC_WID'(w);
            end
        end
    end

    lv1_il_victim_sel #(
        .ASSOC     (ASSOC),
        .ASSOC_WID (ASSOC_WID),
        .SETS      (SETS),
        .IDX_W     (IDX_W)
    ) victimSel (
        .clk       (clk),
        .rst       (rst),
        .set_i     (missIdx),
        .valid_i   (validArr_q[missIdx]),
        .clr_en_i  (state_q == S_INV),
        .clr_set_i (invIdx_q),
        .adv_en_i  (state_q == S_FILL),
        .victim_o  (victimWay)
    );

    always_comb begin
        state_d    = state_q;
        beatCnt_d  = beatCnt_q;
        invIdx_d   = invIdx_q;
        invPend_d  = invPend_q;
        missAddr_d = missAddr_q;
        rspData_d  = rspData_q;
        rspWay_d   = rspWay_q;
        unique case (state_q)
            S_IDLE: begin
                if (inv_all || invPend_q) begin
                    state_d   = S_INV;
                    invIdx_d  = '0;
                    invPend_d = 1'b0;
                end else if (cpu_rd) begin
                    if (cpuHit) begin
                        state_d   = S_RESP;
                        rspData_d = dataArr_q[cpuIdx][hitWay][cpuOff];
                        rspWay_d  = hitWay;
                    end else begin
                        state_d    = S_REQ;
                        missAddr_d = addr_bus_cpu_lv1;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            S_REQ: begin
                if (bus_lv1_lv2_gnt_proc) begin
                    state_d   = S_RD;
                    beatCnt_d = '0;
                end
            end
            // Grant is not re-checked here: the bus stays ours until req drops.
            S_RD: begin
                if (data_in_bus_lv1_lv2) begin
                    beatCnt_d = beatCnt_q + OFF_W'(1);
                    if (beatCnt_q == missOff) begin
                        rspData_d = data_bus_lv1_lv2;
                    end
                    if (beatCnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                rspWay_d = victimWay;
                state_d  = S_RESP;
            end
            S_INV: begin
                invIdx_d = invIdx_q + IDX_W'(1);
                if (invIdx_q == IDX_W'(SETS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (inv_all && (state_q == S_RESP || state_q == S_REQ || state_q == S_RD || state_q == S_FILL)) begin
            invPend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beatCnt_q  <= '0;
            invIdx_q   <= '0;
            invPend_q  <= 1'b0;
            missAddr_q <= '0;
            rspData_q  <= '0;
            rspWay_q   <= '0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            invIdx_q   <= invIdx_d;
            invPend_q  <= invPend_d;
            missAddr_q <= missAddr_d;
            rspData_q  <= rspData_d;
            rspWay_q   <= rspWay_d;
        end
    end

    // Tag/data storage and the fill buffer are never reset; only valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RD && data_in_bus_lv1_lv2) begin
            fillBuf_q[beatCnt_q] <= data_bus_lv1_lv2;
        end
        if (!rst && state_q == S_FILL) begin
            tagArr_q[missIdx][victimWay] <= missTag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                dataArr_q[missIdx][victimWay][w] <= fillBuf_q[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                validArr_q[s] <= '0;
            end
        end else if (state_q == S_FILL) begin
            validArr_q[missIdx][victimWay] <= VALID;
        end else if (state_q == S_INV) begin
            validArr_q[invIdx_q] <= '0;
        end
    end

`ifdef CACHE_IL_PERF_CNT_EN
    logic [CNT_WID-1:0] hitCnt_q, missCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_RESP && !(&hitCnt_q)) begin
                hitCnt_q <= hitCnt_q + CNT_WID'(1);
            end
            if (state_q == S_IDLE && state_d == S_REQ && !(&missCnt_q)) begin
                missCnt_q <= missCnt_q + CNT_WID'(1);
            end
        end
    end

    assign hit_cnt  = hitCnt_q;
    assign miss_cnt = missCnt_q;
`endif

    assign data_in_bus_cpu_lv1_il  = (state_q == S_RESP);
    assign data_bus_cpu_lv1        = rspData_q;
    assign blk_accessed_main       = rspWay_q;
    assign bus_lv1_lv2_req_proc_il = (state_q == S_REQ) || (state_q == S_RD);
    assign lv2_rd                  = (state_q == S_RD);
    assign addr_bus_lv1_lv2        = (state_q == S_RD) ? (missAddr_q & ~LINE_MASK) : '0;
    assign inv_busy                = (state_q == S_INV);

endmodule

// File: tb/tb_cache_block_lv1_il_mw.sv
// Scoreboard testbench for cache_block_lv1_il_mw with a behavioural lv2 responder.
module tb_cache_block_lv1_il_mw;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd;
    logic [31:0] addr_bus_cpu_lv1;
    logic [31:0] data_bus_cpu_lv1;
    logic        data_in_bus_cpu_lv1_il;
    logic        bus_lv1_lv2_req_proc_il;
    logic        bus_lv1_lv2_gnt_proc;
    logic        lv2_rd;
    logic [31:0] addr_bus_lv1_lv2;
    logic [31:0] data_bus_lv1_lv2;
    logic        data_in_bus_lv1_lv2;
    logic        inv_all;
    logic        inv_busy;
    logic [1:0]  blk_accessed_main;
`ifdef CACHE_IL_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    logic [31:0] expData [$];
    logic [1:0]  expWay [$];

    cache_block_lv1_il_mw dut (
        .clk                     (clk),
        .rst                     (rst),
        .cpu_rd                  (cpu_rd),
        .addr_bus_cpu_lv1        (addr_bus_cpu_lv1),
        .data_bus_cpu_lv1        (data_bus_cpu_lv1),
        .data_in_bus_cpu_lv1_il  (data_in_bus_cpu_lv1_il),
        .bus_lv1_lv2_req_proc_il (bus_lv1_lv2_req_proc_il),
        .bus_lv1_lv2_gnt_proc    (bus_lv1_lv2_gnt_proc),
        .lv2_rd                  (lv2_rd),
        .addr_bus_lv1_lv2        (addr_bus_lv1_lv2),
        .data_bus_lv1_lv2        (data_bus_lv1_lv2),
        .data_in_bus_lv1_lv2     (data_in_bus_lv1_lv2),
        .inv_all                 (inv_all),
        .inv_busy                (inv_busy),
`ifdef CACHE_IL_PERF_CNT_EN
        .hit_cnt                 (hit_cnt),
        .miss_cnt                (miss_cnt),
`endif
        .blk_accessed_main       (blk_accessed_main)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hA500_0000 ^ {a[31:2], 2'b00};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One fetch: pushes the expected word/way, plays the lv2 side, compares on the response pulse.
    task automatic applyStimulus(input logic [31:0] addr, input logic expMiss, input logic [1:0] way,
                                 input int invBeat, input int rstBeat, input logic invFirst);
        int cyc;
        int beat;
        int gntWait;
        logic sawReq;
        logic done;
        logic [31:0] base;
        logic [31:0] dumpD;
        logic [1:0]  dumpW;
        cyc = 0;
        beat = 0;
        gntWait = 0;
        sawReq = 1'b0;
        done = 1'b0;
        base = addr & ~32'(LW * 4 - 1);
        expData.push_back(memWord(addr));
        expWay.push_back(way);
        cpu_rd = 1'b1;
        addr_bus_cpu_lv1 = addr;
        inv_all = invFirst;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            data_in_bus_lv1_lv2 = 1'b0;
            inv_all = 1'b0;
            if (invFirst && cyc == 1) checkOutput("invFirst", 32'(inv_busy), 32'd1);
            if (data_in_bus_cpu_lv1_il) begin
                cpu_rd = 1'b0;
                done = 1'b1;
                if (expData.size() == 0) begin
                    checkOutput("sbEmpty", 32'd1, 32'd0);
                end else begin
                    checkOutput("data", data_bus_cpu_lv1, expData.pop_front());
                    checkOutput("way", 32'(blk_accessed_main), 32'(expWay.pop_front()));
                end
            end else if (lv2_rd) begin
                bus_lv1_lv2_gnt_proc = 1'b0;
                if (beat == 0) checkOutput("lineAddr", addr_bus_lv1_lv2, base);
                if (beat == rstBeat) begin
                    rst = 1'b1;
                    cpu_rd = 1'b0;
                    @(posedge clk);
                    #1;
                    checkOutput("rstReq", 32'(bus_lv1_lv2_req_proc_il), 32'd0);
                    checkOutput("rstLv2Rd", 32'(lv2_rd), 32'd0);
                    rst = 1'b0;
                    done = 1'b1;
                    dumpD = expData.pop_front();
                    dumpW = expWay.pop_front();
                end else if (beat < LW) begin
                    data_bus_lv1_lv2 = memWord(base + 32'(4 * beat));
                    data_in_bus_lv1_lv2 = 1'b1;
                    if (beat == invBeat) inv_all = 1'b1;
                    beat++;
                end
            end else if (bus_lv1_lv2_req_proc_il) begin
                sawReq = 1'b1;
                if (gntWait == 2) bus_lv1_lv2_gnt_proc = 1'b1;
                else gntWait++;
            end
        end
        bus_lv1_lv2_gnt_proc = 1'b0;
        if (!done) begin
            checkOutput("timeout", 32'd0, 32'd1);
            cpu_rd = 1'b0;
            expData.delete();
            expWay.delete();
        end else if (rstBeat < 0) begin
            checkOutput("missPath", 32'(sawReq), 32'(expMiss));
            if (!expMiss) checkOutput("hitLatency", 32'(cyc), 32'd1);
            @(posedge clk);
            #1;
            checkOutput("pulseLen", 32'(data_in_bus_cpu_lv1_il), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        int cyc;
        rst = 1'b1;
        cpu_rd = 1'b0;
        addr_bus_cpu_lv1 = '0;
        bus_lv1_lv2_gnt_proc = 1'b0;
        data_bus_lv1_lv2 = '0;
        data_in_bus_lv1_lv2 = 1'b0;
        inv_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstPulse", 32'(data_in_bus_cpu_lv1_il), 32'd0);
        checkOutput("rstReq", 32'(bus_lv1_lv2_req_proc_il), 32'd0);
        checkOutput("rstLv2Rd", 32'(lv2_rd), 32'd0);
        checkOutput("rstInvBusy", 32'(inv_busy), 32'd0);
        checkOutput("rstData", data_bus_cpu_lv1, 32'd0);
        checkOutput("rstAddr", addr_bus_lv1_lv2, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss then hit in the same line
        applyStimulus(32'h0000_1008, 1'b1, 2'd0, -1, -1, 1'b0);
`ifdef CACHE_IL_PERF_CNT_EN
        checkOutput("missCnt", miss_cnt, 32'd1);
`endif
        applyStimulus(32'h0000_100C, 1'b0, 2'd0, -1, -1, 1'b0);
`ifdef CACHE_IL_PERF_CNT_EN
        checkOutput("hitCnt", hit_cnt, 32'd1);
`endif

        // inv_all during a fill: miss still completes, then a full invalidate walk
        applyStimulus(32'h0000_2048, 1'b1, 2'd0, 1, -1, 1'b0);
        cnt = 0;
        cyc = 0;
        while (cyc < 300 && !(cnt > 0 && !inv_busy)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inv_busy) cnt++;
        end
        checkOutput("invLen", 32'(cnt), 32'd64);
        applyStimulus(32'h0000_2048, 1'b1, 2'd0, -1, -1, 1'b0);

        // Five tags into set 0: fill order, round-robin eviction, refetch of evicted tag
        for (int t = 1; t <= 4; t++) begin
            applyStimulus((32'(t) << 10) | 32'h8, 1'b1, 2'(t - 1), -1, -1, 1'b0);
        end
        applyStimulus((32'd5 << 10) | 32'h8, 1'b1, 2'd0, -1, -1, 1'b0);
        applyStimulus((32'd5 << 10) | 32'hC, 1'b0, 2'd0, -1, -1, 1'b0);
        applyStimulus((32'd3 << 10) | 32'h4, 1'b0, 2'd2, -1, -1, 1'b0);
        applyStimulus((32'd1 << 10) | 32'h8, 1'b1, 2'd1, -1, -1, 1'b0);

        // Reset mid-fill, then clean refills
        applyStimulus(32'h0000_3028, 1'b1, 2'd0, -1, 2, 1'b0);
        applyStimulus(32'h0000_3028, 1'b1, 2'd0, -1, -1, 1'b0);
        applyStimulus((32'd5 << 10) | 32'h8, 1'b1, 2'd0, -1, -1, 1'b0);

        // inv_all and cpu_rd together: invalidate first, then the fetch misses
        applyStimulus(32'h0000_3024, 1'b1, 2'd0, -1, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
